pattern_stream_sched: RTL and testbench

Round-robin scheduler that shares one serial `1010111` pattern detector (`fsm_pattern`) between `NREQ` parallel requesters. It accepts a `WIDTH`-bit word from the granted requester and clears the detector before the word. It then shifts the word into the detector MSB-first, one bit per clock, counts detector matches, and returns a tagged result. It sits between the requester ports and the single detector instance, and drives the detector's `reset`, `in` and `clk` domain.

---
 rtl/pattern_stream_sched.sv | 84 ++++++++
 tb/tb_pattern_stream_sched.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pattern_stream_sched.sv
// pattern_stream_sched: round-robin sharing of one serial 1010111 detector between NREQ requesters
module pattern_stream_sched #(
    parameter int NREQ = 4,
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH + 1),
    localparam int IW = $clog2(NREQ),
    localparam int BW = $clog2(WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  det_reset,
    output logic                  det_in,
    input  logic                  det_out,
    output logic                  busy,
    output logic                  res_valid,
    output logic [IW-1:0]         res_id,
    output logic [CW-1:0]         res_hits
);
    typedef enum logic [2:0] {IDLE, FLUSH, SHIFT, DRAIN, REPORT} state_t;
    state_t state, nxt;
    logic [IW-1:0] last, win, id_q;
    logic [WIDTH-1:0] sr;
    logic [BW-1:0] bcnt;
    logic [CW-1:0] hits;
    logic found;
    // search requesters starting just after the last winner
    always_comb begin
        found = 1'b0;
        win = '0;
        for (int i = 1; i <= NREQ; i++)
            if (!found && req_valid[IW'((int'(last) + i) % NREQ)]) begin
                found = 1'b1;
                win = IW'((int'(last) + i) % NREQ);
            end
    end
    // next state and outputs decoded from registered state
    always_comb begin
        nxt = (state == IDLE)  ? (found ? FLUSH : IDLE) :
              (state == FLUSH) ? SHIFT :
              (state == SHIFT) ? ((bcnt == BW'(WIDTH - 1)) ? DRAIN : SHIFT) :
              (state == DRAIN) ? REPORT : IDLE;
        req_ready = (state == IDLE && found) ? (NREQ'(1) << win) : '0;
        det_reset = (state == IDLE) || (state == FLUSH) || (state == REPORT);
        det_in = (state == SHIFT) && sr[WIDTH-1];
        busy = state != IDLE;
        res_valid = state == REPORT;
    end
    // state, grant capture, shifting and hit counting
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            last <= IW'(NREQ - 1);
            id_q <= '0;
            sr <= '0;
            bcnt <= '0;
            hits <= '0;
            res_id <= '0;
            res_hits <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && found) begin
                last <= win;
                id_q <= win;
                sr <= req_data[int'(win)*WIDTH +: WIDTH];
            end
            if (state == FLUSH) begin
                hits <= '0;
                bcnt <= '0;
            end
            if (state == SHIFT) begin
                sr <= {sr[WIDTH-2:0], 1'b0};
                bcnt <= bcnt + BW'(1);
                if (bcnt != '0 && det_out) hits <= hits + CW'(1);
            end
            if (state == DRAIN) begin
                res_id <= id_q;
                res_hits <= hits + CW'(det_out);
            end
        end
    end
endmodule

// File: tb/tb_pattern_stream_sched.sv
// tb_pattern_stream_sched: table-driven and scoreboard checks of the shared detector scheduler
module tb_pattern_stream_sched;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [3:0] req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0] req_ready;
    logic det_reset, det_in, det_out, busy, res_valid;
    logic [1:0] res_id;
    logic [3:0] res_hits;
    logic [6:0] hist;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    typedef struct {int id; logic [7:0] data; int hits;} vec_t;
    typedef struct {int id; int hits;} exp_t;
    vec_t tbl[5];
    exp_t sb[$];

    pattern_stream_sched #(.NREQ(4), .WIDTH(8)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .det_reset(det_reset), .det_in(det_in), .det_out(det_out),
        .busy(busy), .res_valid(res_valid), .res_id(res_id), .res_hits(res_hits)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Moore 1010111 detector model with overlap, cleared by det_reset
    always @(posedge clk) hist <= det_reset ? 7'd0 : {hist[5:0], det_in};
    assign det_out = hist == 7'b1010111;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // scoreboard: compare each result pulse against the oldest expected entry
    always @(negedge clk) begin
        if (res_valid) begin
            if (sb.size() == 0) chk("unexpected_res_valid", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("res_id", 32'(res_id), 32'(e.id));
                chk("res_hits", 32'(res_hits), 32'(e.hits));
            end
        end
        if (busy && req_ready != 0) chk("ready_outside_idle", 32'(req_ready), 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output bit ok);
        int n = 0;
        while (req_ready == 0 && n < 40) begin
            tick();
            n++;
        end
        ok = n < 40;
        if (!ok) chk("grant_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        bit ok;
        int t0;
        tbl[0] = '{0, 8'hAE, 1};
        tbl[1] = '{2, 8'hFF, 0};
        tbl[2] = '{2, 8'h57, 1};
        tbl[3] = '{1, 8'h0A, 0};
        tbl[4] = '{3, 8'hBF, 0};
        repeat (10) tick();
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_det_in", 32'(det_in), 0);
        chk("rst_det_reset", 32'(det_reset), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_id", 32'(res_id), 0);
        chk("rst_res_hits", 32'(res_hits), 0);
        reset = 1'b1;
        tick();
        for (int v = 0; v < 5; v++) begin
            req_valid[tbl[v].id] = 1'b1;
            req_data[tbl[v].id*8 +: 8] = tbl[v].data;
            #1;
            wait_grant(ok);
            chk("grant_onehot", 32'(req_ready), 32'(1) << tbl[v].id);
            sb.push_back('{tbl[v].id, tbl[v].hits});
            tick();
            req_valid = '0;
            chk("flush_det_reset", 32'(det_reset), 1);
            chk("flush_det_in", 32'(det_in), 0);
            for (int k = 0; k < 8; k++) begin
                tick();
                chk("shift_det_in", 32'(det_in), 32'(tbl[v].data[7-k]));
                chk("shift_det_reset", 32'(det_reset), 0);
            end
            tick();
            chk("drain_res_valid", 32'(res_valid), 0);
            tick();
            chk("report_res_valid", 32'(res_valid), 1);
            chk("report_det_reset", 32'(det_reset), 1);
            tick();
            chk("idle_busy", 32'(busy), 0);
            wait_idle();
        end
        req_data = '0;
        req_valid = 4'hF;
        #1;
        for (int g = 0; g < 5; g++) begin
            int id = 0;
            wait_grant(ok);
            for (int i = 0; i < 4; i++) if (req_ready[i]) id = i;
            chk("rr_order", 32'(req_ready), 32'(1) << (g % 4));
            if (g > 0) chk("rr_spacing", 32'(cyc - t0), 12);
            t0 = cyc;
            sb.push_back('{id, 0});
            tick();
        end
        req_valid = '0;
        wait_idle();
        req_valid[2] = 1'b1;
        req_data[23:16] = 8'hAE;
        #1;
        wait_grant(ok);
        chk("rst_test_grant", 32'(req_ready), 32'h4);
        repeat (6) tick();
        req_valid = '0;
        chk("bit4_det_in", 32'(det_in), 1);
        reset = 1'b0;
        tick();
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_det_reset", 32'(det_reset), 1);
        chk("midrst_res_valid", 32'(res_valid), 0);
        chk("midrst_res_hits", 32'(res_hits), 0);
        reset = 1'b1;
        repeat (15) tick();
        req_data = '0;
        req_data[7:0] = 8'h57;
        req_valid = 4'b1001;
        #1;
        wait_grant(ok);
        chk("post_rst_first", 32'(req_ready), 32'h1);
        sb.push_back('{0, 1});
        tick();
        req_valid[0] = 1'b0;
        wait_grant(ok);
        chk("post_rst_second", 32'(req_ready), 32'h8);
        sb.push_back('{3, 0});
        tick();
        req_valid = '0;
        wait_idle();
        req_data = '0;
        req_valid[0] = 1'b1;
        #1;
        wait_grant(ok);
        sb.push_back('{0, 0});
        tick();
        req_valid[0] = 1'b0;
        req_data[23:16] = 8'hAE;
        req_valid[1] = 1'b1;
        req_valid[2] = 1'b1;
        repeat (3) tick();
        req_valid[1] = 1'b0;
        wait_grant(ok);
        chk("withdrawn_skip", 32'(req_ready), 32'h4);
        sb.push_back('{2, 1});
        tick();
        req_valid = '0;
        wait_idle();
        repeat (3) tick();
        chk("sb_empty", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
